// File: rtl/ex_div_unit.sv
// Iterative RV64M divider for the EX stage: radix-2 restoring, one quotient bit per cycle.
// Handles DIV/DIVU/REM/REMU and W variants; stalls the pipeline until the result is ready.
module ex_div_unit #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic            op_rem_q, op_w_q, s1_q, s2_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [CW-1:0]   cnt_q;

  logic            accept, s1, s2, div_zero, ovf, special;
  logic [XLEN-1:0] a1, a2, mag1, mag2, min_v, spec_val;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] q_mag, q_val, r_val, fix_val;

  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v, input logic u,
                                             input logic w);
    if (!w) return v;
    return u ? {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]}
             : {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  // W results are always sign-extended from bit 31, even for unsigned W ops.
  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? ((~v) + XLEN'(1)) : v;
  endfunction

  // Accept stage: operand conditioning and special-case detection
  always_comb begin
    accept   = start & ~flush & ((state == S_IDLE) | (state == S_DONE));
    a1       = ext_op(src1, op[0], op[2]);
    a2       = ext_op(src2, op[0], op[2]);
    s1       = ~op[0] & a1[XLEN-1];
    s2       = ~op[0] & a2[XLEN-1];
    mag1     = neg_if(a1, s1);
    mag2     = neg_if(a2, s2);
    min_v    = op[2] ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                     : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (a2 == '0);
    ovf      = ~op[0] & (a1 == min_v) & (a2 == '1);
    special  = div_zero | ovf;
    if (div_zero) spec_val = op[1] ? a1 : '1;
    else          spec_val = op[1] ? '0 : a1;
    spec_val = word_ext(spec_val, op[2]);
  end

  // Calc stage: one restoring step; W dividends are pre-aligned to the top of quo_q
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
  end

  // Fix stage: sign correction and result selection
  always_comb begin
    q_mag   = op_w_q ? {{(XLEN-WLEN){1'b0}}, quo_q[WLEN-1:0]} : quo_q;
    q_val   = neg_if(q_mag, s1_q ^ s2_q);
    r_val   = neg_if(rem_q, s1_q);
    fix_val = word_ext(op_rem_q ? r_val : q_val, op_w_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) state_nxt = special ? S_DONE : S_CALC;
          else        state_nxt = S_IDLE;
        end
        S_CALC:  if (cnt_q == CW'(1)) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == S_CALC) | (state == S_FIX);
    done      = (state == S_DONE);
    stall_req = accept | busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rem_q <= 1'b0;
      op_w_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      result   <= '0;
    end else if (!flush) begin
      if (accept) begin
        op_rem_q <= op[1];
        op_w_q   <= op[2];
        s1_q     <= s1;
        s2_q     <= s2;
        rem_q    <= '0;
        quo_q    <= op[2] ? {mag1[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : mag1;
        dvsr_q   <= mag2;
        cnt_q    <= op[2] ? CW'(WLEN) : CW'(XLEN);
        if (special) result <= spec_val;
      end else if (state == S_CALC) begin
        rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_q <= cnt_q - CW'(1);
      end else if (state == S_FIX) begin
        result <= fix_val;
      end
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: directed cases plus chained random ops against a native-arithmetic model.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, start;
  logic [2:0]  op;
  logic [63:0] src1, src2;
  logic        busy, stall_req, done;
  logic [63:0] result;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_res = '0;

  ex_div_unit #(.XLEN(64), .WLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op),
    .src1(src1), .src2(src2), .busy(busy), .stall_req(stall_req),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M semantics using the simulator's own division operators.
  function automatic void model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] res, output int lat);
    logic [63:0] x, y, q, r, minv;
    if (o[2]) begin
      x = o[0] ? {32'b0, a[31:0]} : {{32{a[31]}}, a[31:0]};
      y = o[0] ? {32'b0, b[31:0]} : {{32{b[31]}}, b[31:0]};
      minv = 64'hFFFF_FFFF_8000_0000;
    end else begin
      x = a;
      y = b;
      minv = 64'h8000_0000_0000_0000;
    end
    lat = o[2] ? 34 : 66;
    if (y == 64'd0) begin
      q = '1; r = x; lat = 1;
    end else if (!o[0] && x == minv && y == '1) begin
      q = x; r = 64'd0; lat = 1;
    end else if (o[0]) begin
      q = x / y; r = x % y;
    end else begin
      q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
    end
    res = o[1] ? r : q;
    if (o[2]) res = {{32{res[31]}}, res[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: presents the op for the coming rising edge.
  task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input string tag);
    op = o; src1 = a; src2 = b; start = 1'b1;
    #1;
    chk({tag, "_c0_stall"}, {63'b0, stall_req}, 64'd1);
  endtask

  task automatic wait_done(input string tag, input int lat, input logic [63:0] exp);
    bit seen = 1'b0;
    bit stall_ok = 1'b1;
    for (int k = 1; k <= 120 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      #1;
      if (done) begin
        seen = 1'b1;
        chk({tag, "_latency"}, 64'(k), 64'(lat));
        chk({tag, "_result"}, result, exp);
        chk({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
        chk({tag, "_stall_at_done"}, {63'b0, stall_req}, 64'd0);
      end else if (stall_req !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
    chk({tag, "_stall_held"}, {63'b0, stall_ok}, 64'd1);
    last_res = exp;
  endtask

  task automatic check_hold(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
    chk({tag, "_result_held"}, result, last_res);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [63:0] ra, rb, er;
    int          el, done_cnt;

    rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_stall", {63'b0, stall_req}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'b001, 64'd100, 64'd7, "divu");
    wait_done("divu", 66, 64'd14);
    check_hold("divu");

    issue(3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem_neg");
    wait_done("rem_neg", 66, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div_neg");
    wait_done("div_neg", 66, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(3'b000, 64'd5, 64'd0, "div_zero");
    wait_done("div_zero", 1, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(3'b011, 64'd5, 64'd0, "remu_zero");
    wait_done("remu_zero", 1, 64'd5);

    issue(3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div_ovf");
    wait_done("div_ovf", 1, 64'h8000_0000_0000_0000);
    issue(3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "rem_ovf");
    wait_done("rem_ovf", 1, 64'd0);
    issue(3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "divw_ovf");
    wait_done("divw_ovf", 1, 64'hFFFF_FFFF_8000_0000);

    issue(3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1, "divuw");
    wait_done("divuw", 34, 64'hFFFF_FFFF_FFFF_FFFF);
    check_hold("divuw");

    issue(3'b001, 64'd1000, 64'd10, "b2b_a");
    wait_done("b2b_a", 66, 64'd100);
    issue(3'b001, 64'd77, 64'd7, "b2b_b");
    wait_done("b2b_b", 66, 64'd11);
    check_hold("b2b");

    // Abort in c20, then a start coincident with flush.
    issue(3'b001, 64'd500, 64'd3, "flush");
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle_busy", {63'b0, busy}, 64'd0);
    chk("flush_done", {63'b0, done}, 64'd0);
    chk("flush_result", result, last_res);
    op = 3'b001; src1 = 64'd9; src2 = 64'd3; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_stall", {63'b0, stall_req}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_busy", {63'b0, busy}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("flush_no_done", 64'(done_cnt), 64'd0);
    chk("flush_result_kept", result, last_res);

    // Random ops, each new one issued in the previous op's DONE cycle.
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0:       rb = 64'd0;
        1:       rb = '1;
        2:       rb = 64'($urandom_range(1, 20));
        3:       rb = {32'($urandom()), 32'($urandom())} >> $urandom_range(0, 60);
        default: rb = {$urandom(), $urandom()};
      endcase
      if ($urandom_range(0, 7) == 0) ra = ro[2] ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, 63);
      model(ro, ra, rb, er, el);
      issue(ro, ra, rb, $sformatf("rnd%0d", i));
      wait_done($sformatf("rnd%0d", i), el, er);
    end
    check_hold("rnd");

    // Asynchronous reset mid-CALC.
    issue(3'b000, 64'd1234, 64'd5, "rst_mid");
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_done", {63'b0, done}, 64'd0);
    chk("rst_mid_stall", {63'b0, stall_req}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b011, 64'd1234, 64'd5, "post_rst");
    wait_done("post_rst", 66, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
